multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have these ports, one line each: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  8  instruction register opcode field; valid from DECODE onward
- mem_ready  in  1  shared memory has completed the current request this cycle
- alu_zero  in  1  ALU zero flag, valid in EXEC
- mem_req  out  1  memory request, held until mem_ready
- mem_sel  out  1  0 = instruction fetch address, 1 = data address
- mem_we  out  1  memory write strobe, valid with mem_req
- ir_write  out  1  load instruction register
- pc_write  out  1  update PC
- pc_src  out  1  0 = PC+4, 1 = branch target
- reg_dst  out  1  1 = rd, 0 = rt destination
- alu_src  out  1  1 = immediate operand
- alu_op  out  8  ALU operation select
- mem_to_reg  out  1  1 = write-back data from memory
- reg_write  out  1  register file write enable
- illegal  out  1  one-cycle pulse on an undefined opcode
- halted  out  1  controller stopped
- state  out  3  current state encoding
- stall_count  out  16  memory stall cycle counter

Function
REQ-002 Opcodes SHALL be: 0x00 R-type, 0x01 LOAD, 0x02 STORE, 0x03 BEQ, 0x04 ADDI, 0xFF HALT; all other values are illegal.
REQ-003 States SHALL be encoded FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; state SHALL output the encoding.
REQ-004 FETCH: mem_req=1, mem_sel=0, mem_we=0; remain while mem_ready=0.
REQ-005 FETCH with mem_ready=1: ir_write=1, pc_write=1, pc_src=0 in that same cycle (combinational on mem_ready); next state DECODE.
REQ-006 DECODE: capture opcode into an internal op register; 0x00/0x01/0x02/0x03/0x04 -> EXEC; 0xFF -> HALT; other -> illegal=1 for this cycle, next state FETCH.
REQ-007 EXEC alu_op: R-type=0x02, BEQ=0x01, LOAD/STORE/ADDI=0x00; alu_src=1 for LOAD/STORE/ADDI, 0 otherwise.
REQ-008 EXEC transitions: BEQ -> FETCH, with pc_write=1 and pc_src=1 in EXEC only if alu_zero=1; LOAD/STORE -> MEM; R-type/ADDI -> WB.
REQ-009 MEM: mem_req=1, mem_sel=1, mem_we=1 only for STORE; remain while mem_ready=0; on mem_ready, LOAD -> WB and STORE -> FETCH.
REQ-010 WB: reg_write=1 for exactly one cycle; mem_to_reg=1 for LOAD; reg_dst=1 for R-type; next state FETCH.
REQ-011 HALT: halted=1 and all other outputs 0; exit only by reset.
REQ-012 Any output not asserted by REQ-004..011 SHALL be 0, including alu_op=0x00 outside EXEC.
REQ-013 Latency: R-type/ADDI = 4 cycles, LOAD = 5, STORE = 4, BEQ = 3, each with zero memory wait; every cycle with mem_ready=0 adds one cycle.
REQ-014 mem_req SHALL stay asserted without gaps from entry into FETCH/MEM until the cycle mem_ready=1; mem_ready while mem_req=0 is ignored.

Reset
REQ-015 Asserting reset SHALL asynchronously force state=FETCH, op register=0x00, stall_count=0; mem_req becomes 1 (FETCH) only after reset deasserts.
REQ-016 While reset=1 all outputs SHALL be 0 (mem_req gated by reset); reset mid-MEM SHALL abandon the access with no write-back.

Configuration
REQ-017 With macro MULTICYCLE_STALL_CNT_EN defined, stall_count SHALL increment on each cycle with mem_req=1 and mem_ready=0, saturating at 0xFFFF, cleared only by reset.
REQ-018 Without MULTICYCLE_STALL_CNT_EN, stall_count SHALL be tied to 0x0000 and no counter logic SHALL be present.

Verification
REQ-019 ADDI (0x04), mem_ready always 1 -> state sequence 0,1,2,4,0; alu_src=1 in EXEC; reg_write=1 only in WB.
REQ-020 LOAD (0x01), mem_ready low 3 cycles in MEM -> mem_req/mem_sel=1 for 4 MEM cycles; WB with mem_to_reg=1; stall_count=3 with the macro, 0 without.
REQ-021 BEQ (0x03): alu_zero=1 -> pc_write=1, pc_src=1 in EXEC; alu_zero=0 -> pc_write=0; both return to FETCH.
REQ-022 opcode 0x7E -> illegal pulses for 1 cycle in DECODE, back to FETCH, reg_write never set.
REQ-023 HALT (0xFF) -> halted=1 held for 10+ cycles despite mem_ready toggling; reset -> state=0, halted=0.
REQ-024 reset asserted mid-MEM of a STORE -> mem_req and mem_we drop immediately; after release, state=FETCH and stall_count=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences fetch, decode, execute, memory and write-back.
// Optional memory stall counter is built when MULTICYCLE_STALL_CNT_EN is defined.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  opcode,
  input  logic        mem_ready,
  input  logic        alu_zero,
  output logic        mem_req,
  output logic        mem_sel,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_dst,
  output logic        alu_src,
  output logic [7:0]  alu_op,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        illegal,
  output logic        halted,
  output logic [2:0]  state,
  output logic [15:0] stall_count
);

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  localparam logic [7:0] OP_RTYPE = 8'h00;
  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] OP_BEQ   = 8'h03;
  localparam logic [7:0] OP_ADDI  = 8'h04;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  localparam logic [7:0] ALU_ADD   = 8'h00;
  localparam logic [7:0] ALU_SUB   = 8'h01;
  localparam logic [7:0] ALU_FUNCT = 8'h02;

  logic [2:0] curState, nextState;
  logic [7:0] opReg;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      curState <= ST_FETCH;
      opReg    <= OP_RTYPE;
    end else begin
      curState <= nextState;
      if (curState == ST_DECODE) opReg <= opcode;
    end
  end

  assign state = curState;

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    nextState  = curState;
    mem_req    = 1'b0;
    mem_sel    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    halted     = 1'b0;
    // Outputs are held low for the whole reset window, including the FETCH request.
    if (!reset) begin
      case (curState)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            nextState = ST_DECODE;
          end
        end
        ST_DECODE: begin
          case (opcode)
            OP_RTYPE, OP_LOAD, OP_STORE, OP_BEQ, OP_ADDI: nextState = ST_EXEC;
            OP_HALT: nextState = ST_HALT;
            default: begin
              illegal   = 1'b1;
              nextState = ST_FETCH;
            end
          endcase
        end
        ST_EXEC: begin
          case (opReg)
            OP_RTYPE: begin
              alu_op    = ALU_FUNCT;
              nextState = ST_WB;
            end
            OP_BEQ: begin
              alu_op    = ALU_SUB;
              pc_write  = alu_zero;
              pc_src    = alu_zero;
              nextState = ST_FETCH;
            end
            OP_LOAD, OP_STORE: begin
              alu_src   = 1'b1;
              nextState = ST_MEM;
            end
            OP_ADDI: begin
              alu_src   = 1'b1;
              nextState = ST_WB;
            end
            default: nextState = ST_FETCH;
          endcase
        end
        ST_MEM: begin
          mem_req = 1'b1;
          mem_sel = 1'b1;
          mem_we  = (opReg == OP_STORE);
          if (mem_ready) nextState = (opReg == OP_LOAD) ? ST_WB : ST_FETCH;
        end
        ST_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (opReg == OP_LOAD);
          reg_dst    = (opReg == OP_RTYPE);
          nextState  = ST_FETCH;
        end
        ST_HALT: halted = 1'b1;
        default: nextState = ST_FETCH;
      endcase
    end
  end

`ifdef MULTICYCLE_STALL_CNT_EN
  logic [15:0] stallCnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stallCnt <= 16'h0000;
    else if (mem_req && !mem_ready && stallCnt != 16'hFFFF) stallCnt <= stallCnt + 16'h0001;
  end

  assign stall_count = stallCnt;
`else
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; expected output vectors are hand-built per cycle.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  opcode;
  logic        mem_ready;
  logic        alu_zero;
  logic        mem_req, mem_sel, mem_we, ir_write, pc_write, pc_src;
  logic        reg_dst, alu_src, mem_to_reg, reg_write, illegal, halted;
  logic [7:0]  alu_op;
  logic [2:0]  state;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .mem_req(mem_req), .mem_sel(mem_sel), .mem_we(mem_we), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_dst(reg_dst), .alu_src(alu_src),
    .alu_op(alu_op), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal(illegal),
    .halted(halted), .state(state), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Observed output bundle: {req,sel,we,irw,pcw,pcs,rd,asrc,aluop[7:0],m2r,rw,ill,hlt,state[2:0]}
  logic [22:0] obs;
  assign obs = {mem_req, mem_sel, mem_we, ir_write, pc_write, pc_src, reg_dst, alu_src,
                alu_op, mem_to_reg, reg_write, illegal, halted, state};

  function automatic logic [22:0] ev(input logic [2:0] st, input logic req, sel, we, irw, pcw, pcs,
                                     rd, asrc, input logic [7:0] aop, input logic m2r, rw, ill, hlt);
    return {req, sel, we, irw, pcw, pcs, rd, asrc, aop, m2r, rw, ill, hlt, st};
  endfunction

  logic [22:0] fetchRdy, fetchWait, decodeV;
  initial begin
    fetchRdy  = ev(3'd0, 1,0,0,1,1,0,0,0, 8'h00, 0,0,0,0);
    fetchWait = ev(3'd0, 1,0,0,0,0,0,0,0, 8'h00, 0,0,0,0);
    decodeV   = ev(3'd1, 0,0,0,0,0,0,0,0, 8'h00, 0,0,0,0);
  end

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; alu_zero = 1'b0; opcode = 8'h00;
    #2;
    checks++;
    if (obs !== 23'h0 || stall_count !== 16'h0) begin
      errors++; $display("FAIL reset_hold: got %h/%h expected 000000/0000", obs, stall_count);
    end
    @(posedge clk); #1;
    reset = 1'b0; #1;
    checks++;
    if (obs !== fetchRdy) begin
      errors++; $display("FAIL reset_release_fetch: got %h expected %h", obs, fetchRdy);
    end
    mem_ready = 1'b0; #1;
    checks++;
    if (obs !== fetchWait) begin
      errors++; $display("FAIL fetch_wait: got %h expected %h", obs, fetchWait);
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== fetchWait) begin
      errors++; $display("FAIL fetch_hold: got %h expected %h", obs, fetchWait);
    end
  endtask

  task automatic test_addi();
    logic [22:0] expv [4];
    expv = '{fetchRdy, decodeV, ev(3'd2, 0,0,0,0,0,0,0,1, 8'h00, 0,0,0,0),
             ev(3'd4, 0,0,0,0,0,0,0,0, 8'h00, 0,1,0,0)};
    opcode = 8'h04; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (obs !== expv[i]) begin
        errors++; $display("FAIL addi cycle %0d: got %h expected %h", i, obs, expv[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    logic [22:0] expv [4];
    expv = '{fetchRdy, decodeV, ev(3'd2, 0,0,0,0,0,0,0,0, 8'h02, 0,0,0,0),
             ev(3'd4, 0,0,0,0,0,0,1,0, 8'h00, 0,1,0,0)};
    opcode = 8'h00; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (obs !== expv[i]) begin
        errors++; $display("FAIL rtype cycle %0d: got %h expected %h", i, obs, expv[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_stall();
    logic [22:0] expv [8];
    logic        rdy  [8];
    logic [22:0] memV;
    logic [15:0] expStall;
    memV = ev(3'd3, 1,1,0,0,0,0,0,0, 8'h00, 0,0,0,0);
    expv = '{fetchRdy, decodeV, ev(3'd2, 0,0,0,0,0,0,0,1, 8'h00, 0,0,0,0),
             memV, memV, memV, memV, ev(3'd4, 0,0,0,0,0,0,0,0, 8'h00, 1,1,0,0)};
    rdy  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`ifdef MULTICYCLE_STALL_CNT_EN
    expStall = 16'd3;
`else
    expStall = 16'd0;
`endif
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    opcode = 8'h01;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i]; #1;
      checks++;
      if (obs !== expv[i]) begin
        errors++; $display("FAIL load cycle %0d: got %h expected %h", i, obs, expv[i]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (state !== 3'd0 || stall_count !== expStall) begin
      errors++; $display("FAIL load_end: got state %0d stall %0d expected state 0 stall %0d",
                         state, stall_count, expStall);
    end
  endtask

  task automatic test_store();
    logic [22:0] expv [5];
    expv = '{fetchRdy, decodeV, ev(3'd2, 0,0,0,0,0,0,0,1, 8'h00, 0,0,0,0),
             ev(3'd3, 1,1,1,0,0,0,0,0, 8'h00, 0,0,0,0), fetchRdy};
    opcode = 8'h02; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (obs !== expv[i]) begin
        errors++; $display("FAIL store cycle %0d: got %h expected %h", i, obs, expv[i]);
      end
      if (i < 4) begin
        @(posedge clk); #1;
      end
    end
    mem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_beq();
    logic [22:0] expv [4];
    for (int z = 1; z >= 0; z--) begin
      expv = '{fetchRdy, decodeV, ev(3'd2, 0,0,0,0,z[0],z[0],0,0, 8'h01, 0,0,0,0), fetchRdy};
      opcode = 8'h03; mem_ready = 1'b1; alu_zero = z[0];
      for (int i = 0; i < 4; i++) begin
        #1;
        checks++;
        if (obs !== expv[i]) begin
          errors++; $display("FAIL beq z=%0d cycle %0d: got %h expected %h", z, i, obs, expv[i]);
        end
        if (i < 3) begin
          @(posedge clk); #1;
        end
      end
      mem_ready = 1'b0;
      @(posedge clk); #1;
    end
    alu_zero = 1'b0;
  endtask

  task automatic test_illegal();
    logic [22:0] expv [4];
    expv = '{fetchRdy, ev(3'd1, 0,0,0,0,0,0,0,0, 8'h00, 0,0,1,0), fetchWait, fetchWait};
    opcode = 8'h7E; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i >= 2) mem_ready = 1'b0;
      #1;
      checks++;
      if (obs !== expv[i]) begin
        errors++; $display("FAIL illegal cycle %0d: got %h expected %h", i, obs, expv[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    logic [22:0] haltV;
    haltV = ev(3'd5, 0,0,0,0,0,0,0,0, 8'h00, 0,0,0,1);
    opcode = 8'hFF; mem_ready = 1'b1;
    #1;
    checks++;
    if (obs !== fetchRdy) begin
      errors++; $display("FAIL halt_fetch: got %h expected %h", obs, fetchRdy);
    end
    @(posedge clk); #2;
    checks++;
    if (obs !== decodeV) begin
      errors++; $display("FAIL halt_decode: got %h expected %h", obs, decodeV);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      mem_ready = i[0]; opcode = 8'h04; #1;
      checks++;
      if (obs !== haltV) begin
        errors++; $display("FAIL halt_hold cycle %0d: got %h expected %h", i, obs, haltV);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1; #1;
    checks++;
    if (state !== 3'd0 || halted !== 1'b0) begin
      errors++; $display("FAIL halt_reset: got state %0d halted %b expected state 0 halted 0", state, halted);
    end
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic test_store_reset();
    logic [22:0] expv [4];
    expv = '{fetchRdy, decodeV, ev(3'd2, 0,0,0,0,0,0,0,1, 8'h00, 0,0,0,0),
             ev(3'd3, 1,1,1,0,0,0,0,0, 8'h00, 0,0,0,0)};
    opcode = 8'h02;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i < 3); #1;
      checks++;
      if (obs !== expv[i]) begin
        errors++; $display("FAIL store_reset cycle %0d: got %h expected %h", i, obs, expv[i]);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1; #1;
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || obs !== 23'h0) begin
      errors++; $display("FAIL store_reset_drop: got %h expected 000000", obs);
    end
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b0; #1;
    checks++;
    if (obs !== fetchWait || stall_count !== 16'h0) begin
      errors++; $display("FAIL store_reset_release: got %h/%h expected %h/0000", obs, stall_count, fetchWait);
    end
    @(posedge clk); #1;
    checks++;
    if (reg_write !== 1'b0 || state !== 3'd0) begin
      errors++; $display("FAIL store_reset_no_wb: got state %0d reg_write %b expected 0/0", state, reg_write);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_rtype();
    test_load_stall();
    test_store();
    test_beq();
    test_illegal();
    test_halt();
    test_store_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
